base_shiftr_sched: RTL and testbench
====================================

Name: base_shiftr_sched

Overview:
- Down-converting lane scheduler: accepts one wide beat of up to `ways` lanes and emits it as successive `oways`-lane output beats.
- Holds the beat in a register and steps a lane offset that drives a `base_shiftr_enc` instance as its select.
- Sits between a wide producer and a narrower consumer; valid/ready handshake on both sides.

Parameters:
- width, 8, bits per lane.
- ways, 4, input lanes per beat; must be >= 2.
- oways, 2, output lanes per beat; 1 <= oways <= ways.
- cnt_width, $clog2(ways+1), width of the input lane-count field.
- ocnt_width, $clog2(oways+1), width of the output lane-count field.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_v  input  1  input beat valid.
- i_r  output  1  input ready.
- i_d  input  ways*width  input lanes; lane k is bits [(k+1)*width-1:k*width].
- i_cnt  input  cnt_width  number of valid lanes in i_d, starting at lane 0.
- o_v  output  1  output beat valid.
- o_r  input  1  output ready.
- o_d  output  oways*width  output lanes; lane 0 is the lowest-ordered remaining input lane.
- o_cnt  output  ocnt_width  valid lanes in o_d, range 1..oways.
- o_last  output  1  this output beat completes the held input beat.

Behaviour:
- Clock and reset: single clock domain.
  - reset is asynchronous, active-high, and clears all state.
  - While reset is high: o_v=0, i_r=0, o_last=0, o_cnt=0, o_d=0.
  - i_r rises in the first cycle after reset deasserts.
- States: EMPTY, DRAIN. Registers are hold_d, rem (remaining lanes), and off (lane offset, $clog2(ways) bits).
- EMPTY:
  - i_r=1, o_v=0.
  - On i_v & i_cnt!=0: hold_d <= i_d with lanes >= i_cnt forced to zero; rem <= min(i_cnt, ways); off <= 0; go to DRAIN.
  - i_cnt values above ways are clamped to ways.
  - On i_v & i_cnt==0: beat is consumed and dropped; no output; stay in EMPTY.
- DRAIN outputs:
  - o_v=1.
  - o_d = shift-right of hold_d by off lanes, with zeros padding the upper lanes.
  - o_cnt = min(rem, oways).
  - o_last = (rem <= oways).
  - Lanes of o_d at index >= o_cnt are zero.
- DRAIN transitions:
  - o_v & o_r & ~o_last: off <= off+oways; rem <= rem-oways.
  - o_v & o_r & o_last: beat done.
- Back-to-back input: i_r = EMPTY | (DRAIN & o_r & o_last).
  - If a new beat is accepted in the same cycle the last output is accepted, load it and stay in DRAIN. There is no bubble.
  - If no new beat is accepted, go to EMPTY.
- Latency: a beat accepted in cycle N presents its first output in cycle N+1.
  - Throughput is ceil(i_cnt/oways) output beats per input beat.
  - There is one idle output cycle only when the input is not valid.
- Stall: while o_v & ~o_r, all outputs are held stable and i_r=0 in DRAIN.
- off wrap: off never exceeds ways-1 while in DRAIN, because rem > 0 implies off < ways. The sub-module overflow path is never exercised.
- Reset mid-beat: the held beat is discarded and there is no partial output after release.
- oways==ways: every beat is a single o_last output; the block degenerates to a one-stage register slice.

Decomposition:
- Shared package: the state encoding (EMPTY=0, DRAIN=1) and a min helper for count arithmetic. Width helpers come from parameters and are not duplicated.
- Sub-module: one base_shiftr_enc instance with width=width, ways=ways, oways=oways, sel=off. It is the only datapath; masking is done at load.

Test Plan (width=8, ways=4, oways=2):
- Full beat: i_d=0x44332211, i_cnt=4, o_r=1.
  - Cycle 1 response: o_d=0x2211, o_cnt=2, o_last=0.
  - Cycle 2 response: o_d=0x4433, o_cnt=2, o_last=1.
- Partial beat: i_d=0xFF332211, i_cnt=3.
  - First response: o_d=0x2211, o_cnt=2.
  - Second response: o_d=0x0033, o_cnt=1, o_last=1 (lane 3 masked).
- Back-to-back with o_r=1 and i_v held: i_r=1 only on o_last cycles. Four beats give 8 consecutive o_v cycles with no gap.
- Backpressure: o_r=0 for 5 cycles mid-beat. o_d, o_cnt, and o_last stay stable; i_r=0; data resumes correctly once o_r=1.
- Zero and clamp:
  - i_cnt=0 is accepted (i_r=1 that cycle) and o_v never rises.
  - i_cnt=7 is treated as 4, giving exactly two output beats.
- Async reset asserted mid-DRAIN between clock edges: o_v drops immediately. After release, i_r=1 and no stale beat is emitted.

Source files
------------

// File: rtl/base_shiftr_sched_pkg.sv
// ---------------------------------------------------------------------------
// base_shiftr_sched_pkg
// Shared definitions for the down-converting lane scheduler.
//   schedState_e : scheduler state encoding (EMPTY = 0, DRAIN = 1)
//   minU         : unsigned minimum used for lane-count clamping
// ---------------------------------------------------------------------------
package base_shiftr_sched_pkg;

  // EMPTY waits for a wide beat; DRAIN emits it in narrow pieces.
  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } schedState_e;

  // Count arithmetic is done in 32-bit unsigned and truncated by the caller.
  function automatic int unsigned minU(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/base_shiftr_enc.sv
// ---------------------------------------------------------------------------
// base_shiftr_enc
// Lane shifter: presents oways lanes of i_d starting at lane sel, with zero
// lanes shifted in from the top once the input runs out.
// Ports:
//   sel  in   lane offset ($clog2(ways) bits)
//   i_d  in   ways*width input lanes, lane k at [(k+1)*width-1:k*width]
//   o_d  out  oways*width output lanes, lane 0 = input lane sel
// ---------------------------------------------------------------------------
module base_shiftr_enc #(
  parameter int width = 8,
  parameter int ways  = 4,
  parameter int oways = 2,
  localparam int SelW = (ways > 1) ? $clog2(ways) : 1
) (
  input  logic [SelW-1:0]        sel,
  input  logic [ways*width-1:0]  i_d,
  output logic [oways*width-1:0] o_d
);

  logic [ways*width-1:0] shifted;
  int unsigned           shiftAmt;

  // A logical right shift by whole lanes pads the vacated upper lanes with
  // zeros, so lanes beyond the end of the held beat come out as zero.
  always_comb begin
    shiftAmt = int'(sel) * width;
    shifted  = i_d >> shiftAmt;
    o_d      = shifted[oways*width-1:0];
  end

endmodule

// File: rtl/base_shiftr_sched.sv
// ---------------------------------------------------------------------------
// base_shiftr_sched
// Down-converting lane scheduler: takes one wide beat of up to ways lanes and
// emits it as successive oways-lane beats, with valid/ready on both sides.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-high reset
//   i_v     in   input beat valid
//   i_r     out  input ready
//   i_d     in   ways*width input lanes
//   i_cnt   in   valid input lanes from lane 0 (values above ways clamp)
//   o_v     out  output beat valid
//   o_r     in   output ready
//   o_d     out  oways*width output lanes, lane 0 = lowest remaining lane
//   o_cnt   out  valid lanes in o_d (1..oways)
//   o_last  out  this output beat completes the held input beat
// ---------------------------------------------------------------------------
module base_shiftr_sched
  import base_shiftr_sched_pkg::*;
#(
  parameter int width      = 8,
  parameter int ways       = 4,
  parameter int oways      = 2,
  parameter int cnt_width  = $clog2(ways + 1),
  parameter int ocnt_width = $clog2(oways + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_v,
  output logic                   i_r,
  input  logic [ways*width-1:0]  i_d,
  input  logic [cnt_width-1:0]   i_cnt,
  output logic                   o_v,
  input  logic                   o_r,
  output logic [oways*width-1:0] o_d,
  output logic [ocnt_width-1:0]  o_cnt,
  output logic                   o_last
);

  localparam int OffW = (ways > 1) ? $clog2(ways) : 1;

  schedState_e            state_q, state_d;
  logic [ways*width-1:0]  holdData_q, holdData_d;
  logic [cnt_width-1:0]   rem_q, rem_d;
  logic [OffW-1:0]        off_q, off_d;

  logic [ways*width-1:0]  loadData;
  logic [cnt_width-1:0]   loadCnt;
  logic [oways*width-1:0] encData;
  logic [ocnt_width-1:0]  outCnt;
  logic                   outLast;
  logic                   draining;
  logic                   inReady;
  logic                   inAccept;

  // The shifter is the whole output datapath; lanes past the valid count
  // are already zero in holdData_q, so no masking is needed on the way out.
  base_shiftr_enc #(
    .width (width),
    .ways  (ways),
    .oways (oways)
  ) u_enc (
    .sel (off_q),
    .i_d (holdData_q),
    .o_d (encData)
  );

  // Prepare an incoming beat for loading: clamp the lane count to ways and
  // zero every lane at or above it, so a partial final output carries zeros
  // in its unused lanes.
  always_comb begin
    loadCnt  = cnt_width'(minU(32'(i_cnt), 32'(ways)));
    loadData = '0;
    for (int k = 0; k < ways; k++) begin
      if (k < int'(loadCnt)) begin
        loadData[k*width +: width] = i_d[k*width +: width];
      end
    end
  end

  // Output-side view of the held beat. Ready is held low while reset is
  // asserted and otherwise allows a new beat to slip in on the same cycle
  // the last piece of the current beat leaves, which removes the bubble.
  always_comb begin
    draining = (state_q == DRAIN);
    outCnt   = ocnt_width'(minU(32'(rem_q), 32'(oways)));
    outLast  = (int'(rem_q) <= oways);
    inReady  = ~reset & ((state_q == EMPTY) | (draining & o_r & outLast));
    inAccept = i_v & inReady;

    o_v    = draining;
    i_r    = inReady;
    o_d    = draining ? encData : '0;
    o_cnt  = draining ? outCnt : '0;
    o_last = draining & outLast;
  end

  // Next-state logic. A zero-count beat is consumed without producing any
  // output. In DRAIN, a non-final accepted output steps the lane offset;
  // the final one either reloads from a waiting beat or returns to EMPTY.
  always_comb begin
    state_d    = state_q;
    holdData_d = holdData_q;
    rem_d      = rem_q;
    off_d      = off_q;
    unique case (state_q)
      EMPTY: begin
        if (inAccept && (i_cnt != '0)) begin
          holdData_d = loadData;
          rem_d      = loadCnt;
          off_d      = '0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (o_r) begin
          if (!outLast) begin
            off_d = off_q + OffW'(oways);
            rem_d = rem_q - cnt_width'(oways);
          end else if (inAccept && (i_cnt != '0)) begin
            holdData_d = loadData;
            rem_d      = loadCnt;
            off_d      = '0;
          end else begin
            rem_d   = '0;
            off_d   = '0;
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register; reset discards any held beat immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      holdData_q <= '0;
      rem_q      <= '0;
      off_q      <= '0;
    end else begin
      state_q    <= state_d;
      holdData_q <= holdData_d;
      rem_q      <= rem_d;
      off_q      <= off_d;
    end
  end

endmodule

// File: tb/tb_base_shiftr_sched.sv
// ---------------------------------------------------------------------------
// tb_base_shiftr_sched
// Self-checking bench for base_shiftr_sched (width=8, ways=4, oways=2).
// Accepted input beats are expanded into expected output beats and queued;
// every accepted output beat is popped and compared.
// ---------------------------------------------------------------------------
module tb_base_shiftr_sched;

  logic        clk;
  logic        reset;
  logic        iV;
  logic        iR;
  logic [31:0] iD;
  logic [2:0]  iCnt;
  logic        oV;
  logic        oR;
  logic [15:0] oD;
  logic [1:0]  oCnt;
  logic        oLast;

  typedef struct {
    logic [15:0] data;
    int          cnt;
    logic        last;
  } expBeat_t;

  expBeat_t expQ[$];
  int checks = 0;
  int errors = 0;
  int runLen = 0;
  int lastRun = 0;

  base_shiftr_sched #(
    .width (8),
    .ways  (4),
    .oways (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_v    (iV),
    .i_r    (iR),
    .i_d    (iD),
    .i_cnt  (iCnt),
    .o_v    (oV),
    .o_r    (oR),
    .o_d    (oD),
    .o_cnt  (oCnt),
    .o_last (oLast)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference expansion of one input beat into its 2-lane output beats.
  task automatic pushExpected(input logic [31:0] data, input int cnt);
    int           c;
    int           rem;
    int           off;
    int           n;
    logic [31:0]  masked;
    expBeat_t     e;
    c = (cnt > 4) ? 4 : cnt;
    masked = '0;
    for (int k = 0; k < c; k++) masked[k*8 +: 8] = data[k*8 +: 8];
    rem = c;
    off = 0;
    while (rem > 0) begin
      n = (rem < 2) ? rem : 2;
      e.data = '0;
      for (int j = 0; j < n; j++) e.data[j*8 +: 8] = masked[(off+j)*8 +: 8];
      e.cnt  = n;
      e.last = (rem <= 2);
      expQ.push_back(e);
      rem -= n;
      off += 2;
    end
  endtask

  // Monitor on the falling edge: handshakes seen here complete on the next
  // rising edge. Outputs are popped before inputs are pushed so queue order
  // follows the DUT. Also tracks runs of consecutive valid outputs.
  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
      runLen = 0;
    end else begin
      if (oV) begin
        checkOutput("ir_rule", {31'd0, iR}, {31'd0, oR & oLast});
        runLen++;
      end else if (runLen != 0) begin
        lastRun = runLen;
        runLen  = 0;
      end
      if (oV && oR) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out", 32'd1, 32'd0);
        end else begin
          expBeat_t e;
          e = expQ.pop_front();
          checkOutput("o_d", {16'd0, oD}, {16'd0, e.data});
          checkOutput("o_cnt", {30'd0, oCnt}, 32'(e.cnt));
          checkOutput("o_last", {31'd0, oLast}, {31'd0, e.last});
        end
      end
      if (iV && iR) pushExpected(iD, int'(iCnt));
    end
  end

  // Present one input beat and hold it until it is accepted (bounded).
  // Returns just after the accepting edge with i_v still high.
  task automatic applyStimulus(input logic [31:0] data, input logic [2:0] cnt);
    bit got;
    iV   = 1'b1;
    iD   = data;
    iCnt = cnt;
    got  = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (iR) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Wait until all expected outputs are consumed and o_v has fallen.
  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !oV) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    iV    = 1'b0;
    iD    = '0;
    iCnt  = '0;
    oR    = 1'b1;

    // Reset state while reset is held high.
    #3;
    checkOutput("rst_o_v", {31'd0, oV}, 32'd0);
    checkOutput("rst_i_r", {31'd0, iR}, 32'd0);
    checkOutput("rst_o_last", {31'd0, oLast}, 32'd0);
    checkOutput("rst_o_cnt", {30'd0, oCnt}, 32'd0);
    checkOutput("rst_o_d", {16'd0, oD}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_i_r", {31'd0, iR}, 32'd1);

    // Full beat: two 2-lane outputs.
    applyStimulus(32'h44332211, 3'd4);
    iV = 1'b0;
    waitDrain();
    checkOutput("full_run", 32'(lastRun), 32'd2);

    // Partial beat: lane 3 must be masked off.
    applyStimulus(32'hFF332211, 3'd3);
    iV = 1'b0;
    waitDrain();
    checkOutput("partial_run", 32'(lastRun), 32'd2);

    // Back-to-back: four beats with i_v held give eight gapless outputs.
    applyStimulus(32'h04030201, 3'd4);
    applyStimulus(32'h14131211, 3'd4);
    applyStimulus(32'h24232221, 3'd4);
    applyStimulus(32'h34333231, 3'd4);
    iV = 1'b0;
    waitDrain();
    checkOutput("b2b_run", 32'(lastRun), 32'd8);

    // Backpressure on the second output of a beat for five cycles.
    applyStimulus(32'h44332211, 3'd4);
    iV = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    oR = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkOutput("stall_o_d", {16'd0, oD}, 32'h4433);
      checkOutput("stall_o_cnt", {30'd0, oCnt}, 32'd2);
      checkOutput("stall_o_last", {31'd0, oLast}, 32'd1);
      checkOutput("stall_i_r", {31'd0, iR}, 32'd0);
    end
    @(posedge clk);
    #1;
    oR = 1'b1;
    waitDrain();

    // Zero count: accepted immediately, never produces output.
    @(negedge clk);
    checkOutput("zero_i_r", {31'd0, iR}, 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(32'hA5A5A5A5, 3'd0);
    iV = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      checkOutput("zero_o_v", {31'd0, oV}, 32'd0);
    end

    // Clamp: a count of 7 behaves as 4.
    @(posedge clk);
    #1;
    applyStimulus(32'h88776655, 3'd7);
    iV = 1'b0;
    waitDrain();
    checkOutput("clamp_run", 32'(lastRun), 32'd2);

    // Asynchronous reset in the middle of a stalled beat.
    oR = 1'b0;
    applyStimulus(32'hDDCCBBAA, 3'd4);
    iV = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_o_v", {31'd0, oV}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_o_v", {31'd0, oV}, 32'd0);
    checkOutput("async_i_r", {31'd0, iR}, 32'd0);
    checkOutput("async_o_d", {16'd0, oD}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    oR    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rel_i_r", {31'd0, iR}, 32'd1);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      checkOutput("rel_o_v", {31'd0, oV}, 32'd0);
    end
    checkOutput("rel_queue", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
